ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk (rising edge), rst (asynchronous, active-high).
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 a_req, b_req  input  1 each  requester A/B transaction request; held high until the matching ack.
REQ-005 a_wr, b_wr  input  1 each  1 = write, 0 = read; stable while req is high.
REQ-006 a_add, b_add  input  3 each  RAM address; stable while req is high.
REQ-007 a_din, b_din  input  8 each  write data; stable while req is high.
REQ-008 a_ack, b_ack  output  1 each  one-cycle transaction-complete pulse.
REQ-009 rdata  output  8  read data; valid in the cycle the read's ack is high.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 ram_en, ram_wr  output  1 each  RAM enable and write strobe.
REQ-012 ram_add  output  3  RAM address; ram_din  output  8  RAM write data.
REQ-013 ram_dout  input  8  RAM read data, registered inside the RAM on the clk edge where ram_en=1 and ram_wr=0.

Function
REQ-014 The FSM SHALL have four states: IDLE, ACCESS, WAIT, RESP.
REQ-015 In IDLE, when any req is high at a clock edge, the FSM SHALL latch the winner (owner), its wr/add/din and go to ACCESS; with no req it SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: single requester wins; if both request, the one not granted last (last_grant) wins; last_grant updates on every grant.
REQ-017 In ACCESS, ram_en SHALL be 1 and ram_wr/ram_add/ram_din SHALL equal the latched values; in every other state ram_en, ram_wr, ram_add, ram_din SHALL be 0.
REQ-018 ACCESS SHALL go to RESP for a write and to WAIT for a read.
REQ-019 In WAIT, the block SHALL load ram_dout into rdata at the edge leaving WAIT, then go to RESP.
REQ-020 In RESP, the owner's ack SHALL be 1 (the other ack 0); the next edge SHALL return to IDLE.
REQ-021 Latency from req sampled to ack high: write 2 cycles, read 3 cycles; a requester SHALL be re-arbitrated only after returning to IDLE (write 3, read 4 cycles per transaction).
REQ-022 rdata SHALL hold its last loaded value until the next read loads it; writes SHALL NOT change rdata.
REQ-023 Requests and new address/data SHALL be ignored outside IDLE; a req dropped before ack SHALL NOT abort the transaction (ack still issued).
REQ-024 A requester keeping req high after its ack SHALL be treated as a new request in IDLE, still subject to round-robin.
REQ-025 Acks SHALL never be high simultaneously; at most one RAM access SHALL be in flight.

Reset
REQ-026 While rst=1: state IDLE, a_ack=b_ack=0, busy=0, rdata=8'h00, ram_en/ram_wr=0, ram_add=3'b000, ram_din=8'h00, last_grant=B (A wins first contention).
REQ-027 Reset asserted mid-transaction SHALL abandon it immediately with no ack; after release, both requesters SHALL be re-arbitrated from IDLE.

Verification
REQ-028 A write 8'h4B to add 1, then A read add 1 -> write ack 2 cycles after req, ram_en exactly one cycle; read ack 3 cycles after req with rdata=8'h4B.
REQ-029 A and B request together after reset (A write 8'h6F@2, B write 8'h55@4), both held -> A acked first, B acked next; B read @4 returns 8'h55.
REQ-030 A and B hold req continuously for 6 transactions -> grants alternate A,B,A,B,A,B; never simultaneous ack; busy low exactly one cycle between transactions.
REQ-031 B writes 8'h15@7; A reads @7 while B re-reads @7 -> rdata=8'h15 on each ack; a later write to @7 leaves rdata=8'h15 unchanged.
REQ-032 rst pulsed during WAIT of a read -> no ack, all outputs at reset values same cycle; after release, a pending B req is granted and completes normally.
REQ-033 A changes a_add from 1 to 3 during ACCESS -> ram_add stays 1 and rdata returns contents of address 1.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
//
// Shares one single-port RAM between two requesters (A and B). Each requester
// raises req with a stable wr/add/din and holds it until its one-cycle ack.
// A four-state FSM serialises the traffic so that only one RAM access is ever
// in flight. When both requesters contend, round-robin arbitration picks the
// one that was not granted last.
//
// Transaction timing (cycle 0 = the edge where IDLE samples the request):
//   write : ACCESS -> RESP -> IDLE        (ack 2 cycles after req sampled)
//   read  : ACCESS -> WAIT -> RESP -> IDLE (ack 3 cycles after req sampled)
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   a_req / b_req  in   transaction request, held until ack
//   a_wr  / b_wr   in   1 = write, 0 = read
//   a_add / b_add  in   RAM address
//   a_din / b_din  in   write data
//   a_ack / b_ack  out  one-cycle transaction-complete pulse
//   rdata          out  last read data (valid with a read's ack, then held)
//   busy           out  high whenever the FSM is not IDLE
//   ram_en         out  RAM enable (only in ACCESS)
//   ram_wr         out  RAM write strobe
//   ram_add        out  RAM address
//   ram_din        out  RAM write data
//   ram_dout       in   RAM read data, registered inside the RAM
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_wr,
    input  logic [ADDR_W-1:0] a_add,
    input  logic [DATA_W-1:0] a_din,
    input  logic              b_req,
    input  logic              b_wr,
    input  logic [ADDR_W-1:0] b_add,
    input  logic [DATA_W-1:0] b_din,
    output logic              a_ack,
    output logic              b_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              ram_en,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_add,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // Requester encoding used by owner and last_grant: 0 = A, 1 = B.
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   add_q, add_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    // B wins when it is the only requester, or when both request and A was
    // the one granted last. Otherwise A wins (including the idle case, where
    // the result is unused).
    logic grant_b;
    assign grant_b = b_req && (!a_req || (last_grant_q == REQ_A));

    // -----------------------------------------------------------------------
    // Next-state and datapath capture
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        wr_d         = wr_q;
        add_d        = add_q;
        din_d        = din_q;
        rdata_d      = rdata_q;

        case (state_q)
            S_IDLE: begin
                // The request is only looked at here; address/data changes
                // or dropped requests later in the transaction are ignored.
                if (a_req || b_req) begin
                    owner_d      = grant_b ? REQ_B : REQ_A;
                    last_grant_d = grant_b ? REQ_B : REQ_A;
                    wr_d         = grant_b ? b_wr  : a_wr;
                    add_d        = grant_b ? b_add : a_add;
                    din_d        = grant_b ? b_din : a_din;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = wr_q ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                // The RAM registered the read at the ACCESS edge, so its
                // output is valid throughout WAIT.
                rdata_d = ram_dout;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= REQ_A;
            // Start as if B was granted last so A wins the first contention.
            last_grant_q <= REQ_B;
            wr_q         <= 1'b0;
            add_q        <= '0;
            din_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            add_q        <= add_d;
            din_q        <= din_d;
            rdata_q      <= rdata_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (decoded from the registered state, so reset clears them
    // in the same cycle it is asserted)
    // -----------------------------------------------------------------------
    always_comb begin
        ram_en  = 1'b0;
        ram_wr  = 1'b0;
        ram_add = '0;
        ram_din = '0;
        a_ack   = 1'b0;
        b_ack   = 1'b0;

        case (state_q)
            S_ACCESS: begin
                ram_en  = 1'b1;
                ram_wr  = wr_q;
                ram_add = add_q;
                ram_din = din_q;
            end
            S_RESP: begin
                a_ack = (owner_q == REQ_A);
                b_ack = (owner_q == REQ_B);
            end
            default: begin
            end
        endcase
    end

    assign busy  = (state_q != S_IDLE);
    assign rdata = rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter
//
// Bench for ram_port_arbiter. A small RAM with a registered read port sits
// behind the DUT. A transaction-level reference model tracks, per grant, the
// grant edge, the transaction length and the data moved, and derives the
// expected output vector for every cycle from those times.
// ---------------------------------------------------------------------------
module tb_ram_port_arbiter;

    logic       clk;
    logic       rst;
    logic       a_req, b_req, a_wr, b_wr;
    logic [2:0] a_add, b_add;
    logic [7:0] a_din, b_din;
    logic       a_ack, b_ack, busy, ram_en, ram_wr;
    logic [2:0] ram_add;
    logic [7:0] ram_din, ram_dout, rdata;

    int n_chk  = 0;
    int n_fail = 0;

    ram_port_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .a_req   (a_req),
        .a_wr    (a_wr),
        .a_add   (a_add),
        .a_din   (a_din),
        .b_req   (b_req),
        .b_wr    (b_wr),
        .b_add   (b_add),
        .b_din   (b_din),
        .a_ack   (a_ack),
        .b_ack   (b_ack),
        .rdata   (rdata),
        .busy    (busy),
        .ram_en  (ram_en),
        .ram_wr  (ram_wr),
        .ram_add (ram_add),
        .ram_din (ram_din),
        .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM behind the arbiter: write on enable+wr, registered read otherwise.
    logic [7:0] ram_mem [0:7] = '{default: 8'h00};
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr) ram_mem[ram_add] <= ram_din;
            else        ram_dout         <= ram_mem[ram_add];
        end
    end

    logic [23:0] obs;
    assign obs = {a_ack, b_ack, busy, ram_en, ram_wr, ram_add, ram_din, rdata};

    // ---------------- reference model ----------------
    int         m_cyc;           // index of the last clock edge
    int         m_g;             // edge of the current grant, -1 if none
    int         m_d;             // edges from grant to ack: 1 write, 2 read
    int         m_next;          // first edge at which a new grant may happen
    logic       m_owner;         // 0 = A, 1 = B
    logic       m_last;          // last granted requester
    logic       m_wr;
    logic [2:0] m_add;
    logic [7:0] m_din, m_val, m_rdata;
    logic [7:0] m_mem [0:7];
    logic [23:0] exp_vec;

    task automatic model_eval();
        bit act, acc, ack;
        act = (m_g >= 0) && (m_cyc >= m_g) && (m_cyc <= m_g + m_d);
        acc = act && (m_cyc == m_g);
        ack = act && (m_cyc == m_g + m_d);
        exp_vec = {ack && !m_owner, ack && m_owner, act, acc, acc && m_wr,
                   acc ? m_add : 3'd0, acc ? m_din : 8'd0, m_rdata};
    endtask

    task automatic model_reset();
        m_g     = -1;
        m_d     = 1;
        m_last  = 1'b1;
        m_rdata = 8'h00;
        m_next  = m_cyc + 1;
        model_eval();
    endtask

    task automatic model_edge();
        m_cyc++;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_g >= 0 && m_cyc == m_g + m_d && !m_wr) m_rdata = m_val;
        if (m_cyc >= m_next && (a_req || b_req)) begin
            m_owner = b_req && (!a_req || !m_last);
            m_last  = m_owner;
            m_wr    = m_owner ? b_wr  : a_wr;
            m_add   = m_owner ? b_add : a_add;
            m_din   = m_owner ? b_din : a_din;
            m_g     = m_cyc;
            m_d     = m_wr ? 1 : 2;
            m_next  = m_cyc + m_d + 2;
            if (m_wr) m_mem[m_add] = m_din;
            else      m_val = m_mem[m_add];
        end
        model_eval();
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic r, input logic w, input logic [2:0] ad, input logic [7:0] d);
        a_req = r; a_wr = w; a_add = ad; a_din = d;
    endtask

    task automatic set_b(input logic r, input logic w, input logic [2:0] ad, input logic [7:0] d);
        b_req = r; b_wr = w; b_add = ad; b_din = d;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_a(1, 1, 3'd5, 8'hAA);
        set_b(1, 0, 3'd6, 8'hBB);
        step();
        step();
        n_chk++;
        if (obs !== 24'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want %h", obs, 24'h0);
        end
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        rst = 1'b0;
        step();
        n_chk++;
        if (obs !== exp_vec || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_no_req: got %h want %h", obs, exp_vec);
        end
    endtask

    task automatic test_write_read();
        set_a(1, 1, 3'd1, 8'h4B);
        step();
        n_chk++;
        if (obs !== {5'b00111, 3'd1, 8'h4B, 8'h00}) begin
            n_fail++; $display("FAIL wr_access: got %h want %h", obs, {5'b00111, 3'd1, 8'h4B, 8'h00});
        end
        step();
        n_chk++;
        if (a_ack !== 1'b1 || b_ack !== 1'b0 || ram_en !== 1'b0) begin
            n_fail++; $display("FAIL wr_ack_latency: got ack=%b%b en=%b want ack=10 en=0", a_ack, b_ack, ram_en);
        end
        a_req = 1'b0;
        step();
        n_chk++;
        if (busy !== 1'b0 || a_ack !== 1'b0) begin
            n_fail++; $display("FAIL wr_return_idle: got busy=%b ack=%b want 0 0", busy, a_ack);
        end
        set_a(1, 0, 3'd1, 8'h00);
        step();
        n_chk++;
        if (ram_en !== 1'b1 || ram_wr !== 1'b0 || ram_add !== 3'd1) begin
            n_fail++; $display("FAIL rd_access: got en=%b wr=%b add=%0d want 1 0 1", ram_en, ram_wr, ram_add);
        end
        step();
        n_chk++;
        if (a_ack !== 1'b0 || ram_en !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL rd_wait: got ack=%b en=%b busy=%b want 0 0 1", a_ack, ram_en, busy);
        end
        step();
        n_chk++;
        if (a_ack !== 1'b1 || rdata !== 8'h4B) begin
            n_fail++; $display("FAIL rd_ack_data: got ack=%b rdata=%h want 1 4b", a_ack, rdata);
        end
        a_req = 1'b0;
        step();
    endtask

    task automatic test_contention();
        logic q[$];
        pulse_reset();
        set_a(1, 1, 3'd2, 8'h6F);
        set_b(1, 1, 3'd4, 8'h55);
        for (int i = 0; i < 12; i++) begin
            step();
            n_chk++;
            if (obs !== exp_vec) begin
                n_fail++; $display("FAIL contend_model: got %h want %h", obs, exp_vec);
            end
            if (a_ack) begin
                q.push_back(1'b0);
                a_req = 1'b0;
            end
            if (b_ack) begin
                q.push_back(1'b1);
                if (b_wr) b_wr = 1'b0;   // keep req high: new read of @4
                else begin
                    b_req = 1'b0;
                    n_chk++;
                    if (rdata !== 8'h55) begin
                        n_fail++; $display("FAIL contend_b_read: got %h want 55", rdata);
                    end
                end
            end
        end
        n_chk++;
        if (q.size() != 3 || q[0] !== 1'b0 || q[1] !== 1'b1 || q[2] !== 1'b1) begin
            n_fail++; $display("FAIL contend_order: got %0d acks want A,B,B", q.size());
        end
        step();
    endtask

    task automatic test_alternation();
        logic q[$];
        int   idle_run = 0;
        pulse_reset();
        set_a(1, 1, 3'd0, 8'h11);
        set_b(1, 1, 3'd3, 8'h22);
        for (int i = 0; i < 18; i++) begin
            step();
            n_chk++;
            if (obs !== exp_vec) begin
                n_fail++; $display("FAIL alt_model: got %h want %h", obs, exp_vec);
            end
            if (!busy) idle_run++;
            if (a_ack || b_ack) begin
                if (q.size() > 0) begin
                    n_chk++;
                    if (idle_run != 1) begin
                        n_fail++; $display("FAIL alt_idle_gap: got %0d want 1", idle_run);
                    end
                end
                q.push_back(b_ack);
                idle_run = 0;
            end
        end
        n_chk++;
        if (q.size() != 6) begin
            n_fail++; $display("FAIL alt_count: got %0d want 6", q.size());
        end
        for (int i = 0; i < q.size(); i++) begin
            n_chk++;
            if (q[i] !== logic'(i % 2)) begin
                n_fail++; $display("FAIL alt_order_%0d: got %b want %b", i, q[i], logic'(i % 2));
            end
        end
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        step();
        step();
    endtask

    task automatic test_rdata_hold();
        bit done = 0;
        int acks = 0;
        set_b(1, 1, 3'd7, 8'h15);
        for (int i = 0; i < 6 && !done; i++) begin
            step();
            if (b_ack) done = 1;
        end
        n_chk++;
        if (!done) begin
            n_fail++; $display("FAIL hold_b_write: got no ack want ack");
        end
        b_req = 1'b0;
        set_a(1, 0, 3'd7, 8'h00);
        set_b(1, 0, 3'd7, 8'h00);
        for (int i = 0; i < 12; i++) begin
            step();
            n_chk++;
            if (obs !== exp_vec) begin
                n_fail++; $display("FAIL hold_model: got %h want %h", obs, exp_vec);
            end
            if (a_ack || b_ack) begin
                acks++;
                if (a_ack) a_req = 1'b0;
                if (b_ack) b_req = 1'b0;
                n_chk++;
                if (rdata !== 8'h15) begin
                    n_fail++; $display("FAIL hold_read_data: got %h want 15", rdata);
                end
            end
        end
        n_chk++;
        if (acks != 2) begin
            n_fail++; $display("FAIL hold_read_acks: got %0d want 2", acks);
        end
        set_a(1, 1, 3'd7, 8'hA0);
        done = 0;
        for (int i = 0; i < 6 && !done; i++) begin
            step();
            if (a_ack) done = 1;
        end
        a_req = 1'b0;
        step();
        n_chk++;
        if (!done || rdata !== 8'h15) begin
            n_fail++; $display("FAIL hold_after_write: got done=%0d rdata=%h want 1 15", done, rdata);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_a = 0;
        bit saw_b = 0;
        set_a(1, 0, 3'd1, 8'h00);
        step();
        set_b(1, 1, 3'd5, 8'h3C);
        step();
        n_chk++;
        if (obs !== exp_vec || busy !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_in_wait: got %h want %h", obs, exp_vec);
        end
        rst = 1'b1;
        #1;
        model_reset();
        n_chk++;
        if (obs !== 24'h0) begin
            n_fail++; $display("FAIL rstmid_async: got %h want %h", obs, 24'h0);
        end
        a_req = 1'b0;
        step();
        rst = 1'b0;
        step();
        n_chk++;
        if (ram_en !== 1'b1 || ram_add !== 3'd5 || ram_din !== 8'h3C) begin
            n_fail++; $display("FAIL rstmid_b_grant: got en=%b add=%0d din=%h want 1 5 3c", ram_en, ram_add, ram_din);
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (obs !== exp_vec) begin
                n_fail++; $display("FAIL rstmid_model: got %h want %h", obs, exp_vec);
            end
            if (a_ack) saw_a = 1;
            if (b_ack) begin
                saw_b = 1;
                b_req = 1'b0;
            end
            step();
        end
        n_chk++;
        if (saw_a || !saw_b) begin
            n_fail++; $display("FAIL rstmid_acks: got a=%0d b=%0d want a=0 b=1", saw_a, saw_b);
        end
    endtask

    task automatic test_addr_change();
        bit done = 0;
        set_a(1, 1, 3'd3, 8'hC3);
        for (int i = 0; i < 6 && !done; i++) begin
            step();
            if (a_ack) done = 1;
        end
        a_req = 1'b0;
        step();
        set_a(1, 0, 3'd1, 8'h00);
        step();
        a_add = 3'd3;
        #1;
        n_chk++;
        if (ram_add !== 3'd1 || ram_en !== 1'b1) begin
            n_fail++; $display("FAIL addr_change_ram_add: got en=%b add=%0d want 1 1", ram_en, ram_add);
        end
        done = 0;
        for (int i = 0; i < 6 && !done; i++) begin
            step();
            if (a_ack) done = 1;
        end
        n_chk++;
        if (!done || rdata !== 8'h4B) begin
            n_fail++; $display("FAIL addr_change_rdata: got done=%0d rdata=%h want 1 4b", done, rdata);
        end
        a_req = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic       rq [2];
        logic       rw [2];
        logic [2:0] ra [2];
        logic [7:0] rd [2];
        int         acks = 0;
        for (int x = 0; x < 2; x++) begin
            rq[x] = 0; rw[x] = 0; ra[x] = 0; rd[x] = 0;
        end
        for (int c = 0; c < 600; c++) begin
            for (int x = 0; x < 2; x++) begin
                bit inflight;
                inflight = (m_g >= 0) && (m_cyc >= m_g) && (m_cyc < m_g + m_d) && (m_owner == logic'(x));
                if (!rq[x] && $urandom_range(3) == 0) begin
                    rq[x] = 1; rw[x] = 1'($urandom); ra[x] = 3'($urandom); rd[x] = 8'($urandom);
                end else if (inflight && $urandom_range(5) == 0) begin
                    rq[x] = 0;
                end
                if (inflight && $urandom_range(5) == 0) begin
                    ra[x] = 3'($urandom); rd[x] = 8'($urandom);
                end
            end
            set_a(rq[0], rw[0], ra[0], rd[0]);
            set_b(rq[1], rw[1], ra[1], rd[1]);
            step();
            n_chk++;
            if (obs !== exp_vec) begin
                n_fail++; $display("FAIL random_model cycle %0d: got %h want %h", c, obs, exp_vec);
            end
            for (int x = 0; x < 2; x++) begin
                if ((x == 0) ? a_ack : b_ack) begin
                    acks++;
                    if ($urandom_range(1) == 0) begin
                        rq[x] = 1; rw[x] = 1'($urandom); ra[x] = 3'($urandom); rd[x] = 8'($urandom);
                    end else begin
                        rq[x] = 0;
                    end
                end
            end
        end
        n_chk++;
        if (acks < 60) begin
            n_fail++; $display("FAIL random_traffic: got %0d acks want >= 60", acks);
        end
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        step();
        step();
        step();
    endtask

    initial begin
        rst = 1'b1;
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        m_cyc = 0;
        for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
        m_owner = 0; m_wr = 0; m_add = 0; m_din = 0; m_val = 0;
        model_reset();
        #1;
        test_reset();
        test_write_read();
        test_contention();
        test_alternation();
        test_rdata_hold();
        test_reset_mid();
        test_addr_change();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
